// File: rtl/sprite_compositor_if.sv
// Video timing, sprite configuration, sprite ROM and composited pixel signals
// for the multi-sprite compositor, bundled into one interface.
interface sprite_compositor_if #(
  parameter int unsigned N_SPR      = 4,
  parameter int unsigned LOG_FRAMES = 2
);
  // Raster position and timing
  logic [10:0]                        hcount;
  logic [9:0]                         vcount;
  logic                               hsync;
  logic                               vsync;
  logic                               blank;

  // Sprite configuration, packed per channel
  logic [11*N_SPR-1:0]                spr_x;
  logic [10*N_SPR-1:0]                spr_y;
  logic [N_SPR-1:0]                   spr_en;
  logic [N_SPR-1:0]                   spr_anim;
  logic [9:0]                         wave_prof;

  // Synchronous sprite ROM, one port per channel
  logic [(LOG_FRAMES+10)*N_SPR-1:0]   rom_addr;
  logic [12*N_SPR-1:0]                rom_data;

  // Composited pixel stream
  logic [11:0]                        p_rgb;
  logic                               p_hsync;
  logic                               p_vsync;
  logic                               p_blank;
  logic                               frame_tick;

  modport master (
    output hcount, vcount, hsync, vsync, blank,
    output spr_x, spr_y, spr_en, spr_anim, wave_prof,
    output rom_data,
    input  rom_addr,
    input  p_rgb, p_hsync, p_vsync, p_blank, frame_tick
  );

  modport slave (
    input  hcount, vcount, hsync, vsync, blank,
    input  spr_x, spr_y, spr_en, spr_anim, wave_prof,
    input  rom_data,
    output rom_addr,
    output p_rgb, p_hsync, p_vsync, p_blank, frame_tick
  );
endinterface

// File: rtl/sprite_compositor.sv
// Multi-sprite pixel compositor: N_SPR prioritised, colour-keyed, animated
// sprites over a wave-split two-colour background, in a 2-cycle pipeline
// matched to a synchronous sprite ROM. Sprite positions are latched once per
// video frame so a frame never shows a half-updated layout.
module sprite_compositor #(
  parameter int unsigned N_SPR      = 4,
  parameter int unsigned W          = 20,
  parameter int unsigned H          = 20,
  parameter int unsigned LOG_FRAMES = 2,
  parameter int unsigned FRAME_DIV  = 8,
  parameter logic [11:0] KEY        = 12'h000,
  parameter logic [11:0] ABOVE_RGB  = 12'hFFF,
  parameter logic [11:0] BELOW_RGB  = 12'h00F
) (
  input logic                vclock,
  input logic                reset,
  sprite_compositor_if.slave bus
);

  localparam int unsigned AW   = LOG_FRAMES + 10;
  localparam int unsigned DivW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(FRAME_DIV - 1);

  logic                  vsync_q;
  logic                  fb;
  logic                  step;
  logic [DivW-1:0]       div_q;
  logic [LOG_FRAMES-1:0] anim_q [N_SPR];

  logic [N_SPR-1:0]      en_s;
  logic [10:0]           x_s [N_SPR];
  logic [9:0]            y_s [N_SPR];

  logic [N_SPR-1:0]      hit;
  logic [AW*N_SPR-1:0]   rom_addr_c;
  logic                  below;

  logic [N_SPR-1:0]      hit1;
  logic                  below1;
  logic                  hsync1;
  logic                  vsync1;
  logic                  blank1;

  logic [11:0]           rgb_d;
  logic [11:0]           p_rgb_q;
  logic                  p_hsync_q;
  logic                  p_vsync_q;
  logic                  p_blank_q;

  // Falling edge of vsync marks the frame boundary; gated so a boundary
  // during reset has no effect.
  assign fb   = vsync_q & ~bus.vsync & ~reset;
  assign step = fb & (div_q == DivLast);

  // Previous vsync, for frame boundary detection
  always_ff @(posedge vclock) begin
    if (reset) vsync_q <= 1'b1;
    else       vsync_q <= bus.vsync;
  end

  // Shadow copy of sprite layout, taken only at a frame boundary
  always_ff @(posedge vclock) begin
    if (reset) begin
      en_s <= '0;
      for (int i = 0; i < N_SPR; i++) begin
        x_s[i] <= '0;
        y_s[i] <= '0;
      end
    end else if (fb) begin
      en_s <= bus.spr_en;
      for (int i = 0; i < N_SPR; i++) begin
        x_s[i] <= bus.spr_x[11*i +: 11];
        y_s[i] <= bus.spr_y[10*i +: 10];
      end
    end
  end

  // Frame divider: one animation step every FRAME_DIV boundaries
  always_ff @(posedge vclock) begin
    if (reset)                  div_q <= '0;
    else if (fb && div_q == DivLast) div_q <= '0;
    else if (fb)                div_q <= div_q + 1'b1;
  end

  // Per-channel animation frame; disabled channels are pinned to frame 0
  always_ff @(posedge vclock) begin
    for (int i = 0; i < N_SPR; i++) begin
      if (reset || !bus.spr_anim[i]) anim_q[i] <= '0;
      else if (step)                 anim_q[i] <= anim_q[i] + 1'b1;
    end
  end

  assign bus.frame_tick = step;

  // Stage 0: hit test in 12 bits so edges near the limits never wrap,
  // and ROM address from the in-sprite offset
  always_comb begin
    hit        = '0;
    rom_addr_c = '0;
    for (int i = 0; i < N_SPR; i++) begin
      hit[i] = en_s[i]
             & ({1'b0, bus.hcount} >= {1'b0, x_s[i]})
             & ({1'b0, bus.hcount} <  ({1'b0, x_s[i]} + 12'(W)))
             & ({2'b0, bus.vcount} >= {2'b0, y_s[i]})
             & ({2'b0, bus.vcount} <  ({2'b0, y_s[i]} + 12'(H)));
      rom_addr_c[AW*i +: AW] = {anim_q[i],
                                5'(bus.vcount - y_s[i]),
                                5'(bus.hcount - x_s[i])};
    end
  end

  assign bus.rom_addr = rom_addr_c;
  assign below        = bus.vcount > bus.wave_prof;

  // Stage 1: hold hit mask, background side and timing while ROM reads
  always_ff @(posedge vclock) begin
    if (reset) begin
      hit1   <= '0;
      below1 <= 1'b0;
      hsync1 <= 1'b1;
      vsync1 <= 1'b1;
      blank1 <= 1'b1;
    end else begin
      hit1   <= hit;
      below1 <= below;
      hsync1 <= bus.hsync;
      vsync1 <= bus.vsync;
      blank1 <= bus.blank;
    end
  end

  // Stage 2 select: lowest opaque hitting channel wins, else background.
  // Scanning from the top down lets the lowest index overwrite last.
  always_comb begin
    rgb_d = below1 ? BELOW_RGB : ABOVE_RGB;
    for (int i = int'(N_SPR) - 1; i >= 0; i--) begin
      if (hit1[i] && (bus.rom_data[12*i +: 12] != KEY)) rgb_d = bus.rom_data[12*i +: 12];
    end
    if (blank1) rgb_d = 12'h000;
  end

  // Stage 2 output register
  always_ff @(posedge vclock) begin
    if (reset) begin
      p_rgb_q   <= 12'h000;
      p_hsync_q <= 1'b1;
      p_vsync_q <= 1'b1;
      p_blank_q <= 1'b1;
    end else begin
      p_rgb_q   <= rgb_d;
      p_hsync_q <= hsync1;
      p_vsync_q <= vsync1;
      p_blank_q <= blank1;
    end
  end

  assign bus.p_rgb   = p_rgb_q;
  assign bus.p_hsync = p_hsync_q;
  assign bus.p_vsync = p_vsync_q;
  assign bus.p_blank = p_blank_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: placement, priority, colour key,
// background split, timing delay, animation stepping, frame-boundary
// latching, mid-frame reset and right-edge placement.
module tb_sprite_compositor;

  localparam int unsigned NSpr = 4;
  localparam int unsigned LogF = 2;

  logic vclock;
  logic reset;
  int   checks;
  int   errors;
  logic [12*NSpr-1:0] rom_color;

  sprite_compositor_if #(.N_SPR(NSpr), .LOG_FRAMES(LogF)) bus ();

  sprite_compositor #(
    .N_SPR     (NSpr),
    .W         (20),
    .H         (20),
    .LOG_FRAMES(LogF),
    .FRAME_DIV (8),
    .KEY       (12'h000),
    .ABOVE_RGB (12'hFFF),
    .BELOW_RGB (12'h00F)
  ) dut (
    .vclock(vclock),
    .reset (reset),
    .bus   (bus)
  );

  initial vclock = 1'b0;
  always #5 vclock = ~vclock;

  // Synchronous ROM model: each channel returns its programmed colour one
  // cycle after the address.
  always @(posedge vclock) bus.rom_data <= rom_color;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge vclock);
    #1;
  endtask

  task automatic pix(input int h, input int v, input logic [11:0] exp, input string tag);
    bus.hcount = 11'(h);
    bus.vcount = 10'(v);
    step();
    step();
    check(tag, 32'(bus.p_rgb), 32'(exp));
  endtask

  task automatic fbound();
    bus.vsync = 1'b0;
    step();
    bus.vsync = 1'b1;
    step();
  endtask

  task automatic set_spr(input int i, input int x, input int y);
    bus.spr_x[11*i +: 11] = 11'(x);
    bus.spr_y[10*i +: 10] = 10'(y);
  endtask

  logic hs_h [16];
  logic vs_h [16];
  logic bl_h [16];

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.hcount    = '0;
    bus.vcount    = '0;
    bus.hsync     = 1'b1;
    bus.vsync     = 1'b1;
    bus.blank     = 1'b0;
    bus.spr_x     = '0;
    bus.spr_y     = '0;
    bus.spr_en    = '0;
    bus.spr_anim  = '0;
    bus.wave_prof = 10'd1023;
    bus.rom_data  = '0;
    rom_color     = '0;

    // Reset state
    step();
    step();
    check("rst_rgb",   32'(bus.p_rgb), 32'h000);
    check("rst_hsync", 32'(bus.p_hsync), 32'd1);
    check("rst_vsync", 32'(bus.p_vsync), 32'd1);
    check("rst_blank", 32'(bus.p_blank), 32'd1);
    check("rst_tick",  32'(bus.frame_tick), 32'd0);
    reset = 1'b0;
    step();

    // Single sprite placement and edges
    set_spr(0, 100, 200);
    bus.spr_en = 4'b0001;
    rom_color[11:0] = 12'h0F0;
    fbound();
    pix(100, 200, 12'h0F0, "s0_origin");
    pix(99,  200, 12'hFFF, "s0_left_out");
    pix(120, 200, 12'hFFF, "s0_right_out");
    pix(119, 200, 12'h0F0, "s0_right_in");
    pix(100, 219, 12'h0F0, "s0_bottom_in");
    pix(100, 220, 12'hFFF, "s0_bottom_out");
    bus.hcount = 11'd105;
    bus.vcount = 10'd203;
    #1;
    check("s0_addr", 32'(bus.rom_addr[11:0]), 32'd101);  // {0, 3, 5}

    // Overlap priority and colour key
    set_spr(0, 300, 300);
    set_spr(1, 290, 295);
    bus.spr_en = 4'b0011;
    rom_color[11:0]  = 12'h000;
    rom_color[23:12] = 12'hF0F;
    fbound();
    pix(305, 305, 12'hF0F, "ovl_key");
    rom_color[11:0] = 12'h0F0;
    pix(305, 305, 12'h0F0, "ovl_prio");
    pix(291, 296, 12'hF0F, "ovl_only1");

    // Background split and blanking
    bus.spr_en = '0;
    fbound();
    bus.wave_prof = 10'd400;
    pix(10, 400, 12'hFFF, "bg_above");
    pix(10, 401, 12'h00F, "bg_below");
    bus.blank = 1'b1;
    pix(10, 401, 12'h000, "bg_blank");
    bus.blank = 1'b0;

    // Timing signals delayed by exactly two cycles
    for (int c = 0; c < 12; c++) begin
      int p;
      p = (c * 5 + 3) % 8;
      hs_h[c] = p[0];
      vs_h[c] = p[1];
      bl_h[c] = p[2];
      bus.hsync = hs_h[c];
      bus.vsync = vs_h[c];
      bus.blank = bl_h[c];
      step();
      if (c >= 1) begin
        check("dly_hsync", 32'(bus.p_hsync), 32'(hs_h[c-1]));
        check("dly_vsync", 32'(bus.p_vsync), 32'(vs_h[c-1]));
        check("dly_blank", 32'(bus.p_blank), 32'(bl_h[c-1]));
      end
    end
    bus.hsync = 1'b1;
    bus.vsync = 1'b1;
    bus.blank = 1'b0;
    bus.wave_prof = 10'd1023;
    step();

    // Animation: restart counters from reset
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    set_spr(0, 100, 200);
    set_spr(1, 400, 200);
    bus.spr_en   = 4'b0011;
    bus.spr_anim = 4'b0001;
    for (int f = 1; f <= 32; f++) begin
      bus.vsync = 1'b0;
      #1;
      check("anim_tick", 32'(bus.frame_tick), 32'((f % 8) == 0));
      step();
      bus.vsync = 1'b1;
      check("anim_tick_off", 32'(bus.frame_tick), 32'd0);
      step();
      bus.hcount = 11'd100;
      bus.vcount = 10'd200;
      #1;
      check("anim_frame0", 32'(bus.rom_addr[11:10]), 32'((f / 8) % 4));
      bus.hcount = 11'd400;
      #1;
      check("anim_frame1", 32'(bus.rom_addr[23:22]), 32'd0);
    end

    // Mid-frame position change waits for the next boundary
    rom_color[11:0]  = 12'h0F0;
    rom_color[23:12] = 12'hF0F;
    set_spr(0, 500, 200);
    pix(105, 205, 12'h0F0, "mid_old_pos");
    pix(505, 205, 12'hFFF, "mid_new_early");
    fbound();
    pix(505, 205, 12'h0F0, "mid_new_pos");
    pix(105, 205, 12'hFFF, "mid_old_gone");

    // Mid-frame reset: black while held, background until next boundary
    reset = 1'b1;
    step();
    step();
    step();
    check("mrst_held", 32'(bus.p_rgb), 32'h000);
    reset = 1'b0;
    pix(505, 205, 12'hFFF, "mrst_bg_only");
    fbound();
    pix(505, 205, 12'h0F0, "mrst_after_fb");

    // Right-edge sprite must not wrap to column 0
    bus.spr_en = 4'b0001;
    set_spr(0, 1020, 200);
    fbound();
    pix(1020, 200, 12'h0F0, "edge_first");
    pix(1039, 200, 12'h0F0, "edge_last");
    pix(1040, 200, 12'hFFF, "edge_past");
    pix(0,    200, 12'hFFF, "edge_nowrap0");
    pix(5,    200, 12'hFFF, "edge_nowrap5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Pixel compositor for the XVGA display path. Replaces the single-sprite display stage.
- Overlays N_SPR independently positioned, animated 20x20-class sprites, using fixed index priority and a colour-key transparency, over a two-colour background split by the wave profile.
- Runs a 2-cycle pipeline against a synchronous sprite ROM and delays hsync/vsync/blank to match.
- Sprite positions are double-buffered per video frame, so there is no tearing.

Parameters:
N_SPR, 4, number of sprite channels; index 0 has the highest priority
W, 20, sprite width in pixels (max 32)
H, 20, sprite height in pixels (max 32)
LOG_FRAMES, 2, log2 of animation frames per sprite
FRAME_DIV, 8, video frames per animation step (>=1)
KEY, 12'h000, transparent colour
ABOVE_RGB, 12'hFFF, colour above the wave profile
BELOW_RGB, 12'h00F, colour below the wave profile

Ports:
vclock  in  1  65 MHz pixel clock
reset  in  1  synchronous, active-high
hcount  in  11  pixel column, 0 at left
vcount  in  10  pixel row, 0 at top
hsync  in  1  active low
vsync  in  1  active low
blank  in  1  active high
spr_x  in  11*N_SPR  sprite left edge; channel i at [11i+10:11i]
spr_y  in  10*N_SPR  sprite top edge
spr_en  in  N_SPR  sprite visible
spr_anim  in  N_SPR  animation enable per sprite
wave_prof  in  10  wave row for the current column
rom_addr  out  (LOG_FRAMES+10)*N_SPR  per channel {frame, py[4:0], px[4:0]}
rom_data  in  12*N_SPR  per channel ROM pixel, valid 1 cycle after rom_addr
p_rgb  out  12  composited pixel
p_hsync  out  1  hsync delayed 2 cycles
p_vsync  out  1  vsync delayed 2 cycles
p_blank  out  1  blank delayed 2 cycles
frame_tick  out  1  one-cycle pulse on each animation step

Behaviour:
- Frame boundary:
  - fb = vsync_q & ~vsync, where vsync_q is vsync registered on vclock.
  - On fb, copy spr_x, spr_y and spr_en into shadow registers. All compare and address logic uses only the shadow registers.
  - Inputs may change at any time without effect until the next fb.
- Animation:
  - div counter 0..FRAME_DIV-1 increments on fb.
  - On fb with div==FRAME_DIV-1: div wraps to 0 and frame_tick=1 for exactly that cycle. Each channel with spr_anim=1 advances anim[i] modulo 2^LOG_FRAMES (3 wraps to 0 at default).
  - A channel with spr_anim=0 holds anim[i]=0, forced on every cycle.
  - FRAME_DIV=1 gives a step on every fb.
- Stage 0 (cycle t, combinational):
  - hit[i] = en_s[i] & hcount>=x_s[i] & hcount<x_s[i]+W & vcount>=y_s[i] & vcount<y_s[i]+H.
  - Compute these compares in 12 bits so a sprite near the right or bottom edge does not wrap.
  - rom_addr[i] = {anim[i], (vcount-y_s[i])[4:0], (hcount-x_s[i])[4:0]}. Don't-care when hit[i]=0.
- Stage 1 register (end of t): hit1 <= hit, below1 <= (vcount > wave_prof), sync and blank delay stage 1.
- Stage 2 (cycle t+1, combinational then registered):
  - Winner = lowest i with hit1[i] & rom_data[i]!=KEY.
  - With a winner: p_rgb <= rom_data[winner]. Otherwise p_rgb <= below1 ? BELOW_RGB : ABOVE_RGB.
  - If the stage-1 blank is 1: p_rgb <= 0.
- Latency: p_rgb, p_hsync, p_vsync and p_blank in cycle t+2 all correspond to hcount/vcount in cycle t.
- Reset:
  - Outputs: p_rgb=0, p_hsync=1, p_vsync=1, p_blank=1, frame_tick=0.
  - State: pipeline hit1=0; shadow regs en_s=0, x_s=0, y_s=0; div=0; anim=0; vsync_q=1.
  - If reset is asserted mid-frame, no sprite is visible until the first fb after release; only the background is shown.
  - An fb that coincides with reset is ignored.
- Overlap: any number of channels may hit at once. Priority depends only on index, never on ROM contents other than KEY.

Test Plan:
- Reset, then one fb with spr_x[0]=100, spr_y[0]=200, en[0]=1 and ROM returning 12'h0F0 -> p_rgb=0F0 2 cycles after hcount=100, vcount=200; background 2 cycles after hcount=99 and after hcount=120; hcount=119 is still the sprite.
- Sprites 0 and 1 overlap at (300,300), ROM0=12'h000 and ROM1=12'hF0F -> F0F; with ROM0=12'h0F0 -> 0F0.
- No sprite, wave_prof=400 -> vcount=400 gives FFF, vcount=401 gives 00F; blank=1 -> p_rgb=0; p_hsync, p_vsync and p_blank equal the inputs delayed exactly 2 cycles.
- FRAME_DIV=8, spr_anim[0]=1 -> frame_tick pulses on the 8th, 16th, ... fb; rom_addr frame field steps 0,1,2,3,0; a channel with spr_anim=0 stays at 0.
- Change spr_x[0] mid-frame -> output unchanged until after the next fb. Reset asserted mid-frame -> p_rgb=0 while reset is held; after release, background only until the next fb.
- Sprite at spr_x=1020, W=20 -> visible for hcount 1020..1039 with no wrap to column 0.
